// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry, parity modes and the receiver state encoding.
package uart_pkg;

  localparam int DATA_BITS = 8;

  // Parity-mode encodings as seen on the parity-select input
  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_IDLE
  } uart_state_t;

  // Parity bit a transmitter places after the data for the given mode
  function automatic logic parity_calc(input logic [DATA_BITS-1:0] data,
                                       input logic                 mode);
    return (^data) ^ mode;
  endfunction

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the idle (high) level.
module uart_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  logic meta;

  // Double-register the line so downstream logic sees a settled level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b1;
      dout <= 1'b1;
    end else begin
      meta <= din;
      dout <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start/8 data/optional parity/stop, mid-bit sampling, parity and framing checks.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_PER_BIT = 16
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 wejscie_odb,
  input  logic                 czy_parz,
  input  logic                 jaki_parz,
  output logic [DATA_BITS-1:0] slowo_odb,
  output logic                 gotowe,
  output logic                 odbior,
  output logic                 blad_parz,
  output logic                 blad_ramki
);

  localparam int CNT_W = $clog2(CLK_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLK_PER_BIT / 2 - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  uart_state_t state, state_n;

  logic                 rx_s;
  logic                 rx_prev;
  logic [CNT_W-1:0]     cnt, cnt_n;
  logic [IDX_W-1:0]     bit_idx, bit_n;
  logic [DATA_BITS-1:0] shift, shift_n;
  logic                 par_en, par_en_n;
  logic                 par_odd, par_odd_n;
  logic                 par_err, par_err_n;
  logic                 done;
  logic                 stop_bad;

  uart_sync u_sync (
    .clk   (CLK),
    .rst_n (RST_N),
    .din   (wejscie_odb),
    .dout  (rx_s)
  );

  // A frame is in progress whenever the FSM is past IDLE and not parked after a framing error
  assign odbior = (state != IDLE) && (state != WAIT_IDLE);

  // State register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_n;
  end

  // Next-state logic plus next values of the bit timer, bit index, shift register and parity tracking
  always_comb begin
    state_n   = state;
    cnt_n     = cnt + CNT_W'(1);
    bit_n     = bit_idx;
    shift_n   = shift;
    par_en_n  = par_en;
    par_odd_n = par_odd;
    par_err_n = par_err;
    done      = 1'b0;
    stop_bad  = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (rx_prev && !rx_s) begin
          // Frame settings are frozen here so mid-frame changes cannot corrupt it
          state_n   = START;
          bit_n     = '0;
          par_en_n  = czy_parz;
          par_odd_n = jaki_parz;
          par_err_n = 1'b0;
        end
      end
      START: begin
        if (cnt == CNT_HALF) begin
          cnt_n   = '0;
          state_n = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == CNT_LAST) begin
          cnt_n            = '0;
          shift_n[bit_idx] = rx_s;
          bit_n            = bit_idx + IDX_W'(1);
          if (bit_idx == IDX_LAST) state_n = par_en ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (cnt == CNT_LAST) begin
          cnt_n     = '0;
          par_err_n = (rx_s != parity_calc(shift, par_odd));
          state_n   = STOP;
        end
      end
      STOP: begin
        if (cnt == CNT_LAST) begin
          cnt_n    = '0;
          done     = 1'b1;
          stop_bad = !rx_s;
          // A valid stop returns straight to IDLE so the next start edge is caught with no gap
          state_n  = rx_s ? IDLE : WAIT_IDLE;
        end
      end
      WAIT_IDLE: begin
        cnt_n = '0;
        if (rx_s) state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Bit timer, bit index, shift register, captured frame settings and edge-detect history
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
      par_en  <= 1'b0;
      par_odd <= 1'b0;
      par_err <= 1'b0;
      rx_prev <= 1'b1;
    end else begin
      cnt     <= cnt_n;
      bit_idx <= bit_n;
      shift   <= shift_n;
      par_en  <= par_en_n;
      par_odd <= par_odd_n;
      par_err <= par_err_n;
      rx_prev <= rx_s;
    end
  end

  // Result registers: word held until the next frame, flags live only alongside the one-cycle done pulse
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      slowo_odb  <= '0;
      gotowe     <= 1'b0;
      blad_parz  <= 1'b0;
      blad_ramki <= 1'b0;
    end else begin
      gotowe     <= done;
      blad_parz  <= done & par_err;
      blad_ramki <= done & stop_bad;
      if (done) slowo_odb <= shift;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: serial frames driven bit by bit, expected words queued in a scoreboard.
module tb_uart_rx;

  localparam int CPB = 16;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       wejscie_odb;
  logic       czy_parz;
  logic       jaki_parz;
  logic [7:0] slowo_odb;
  logic       gotowe;
  logic       odbior;
  logic       blad_parz;
  logic       blad_ramki;

  typedef struct {
    logic [7:0] d;
    logic       perr;
    logic       ferr;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc      = 0;
  int   t_prev   = -1;
  int   t_last   = -1;

  uart_rx #(.CLK_PER_BIT(CPB)) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .wejscie_odb (wejscie_odb),
    .czy_parz    (czy_parz),
    .jaki_parz   (jaki_parz),
    .slowo_odb   (slowo_odb),
    .gotowe      (gotowe),
    .odbior      (odbior),
    .blad_parz   (blad_parz),
    .blad_ramki  (blad_ramki)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Output monitor: every gotowe pulse consumes one scoreboard entry
  always @(negedge CLK) begin
    exp_t e;
    if (RST_N && gotowe) begin
      t_prev = t_last;
      t_last = cyc;
      if (sb.size() == 0) begin
        chk("unexpected_gotowe", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("slowo_odb", {24'd0, slowo_odb}, {24'd0, e.d});
        chk("blad_parz", {31'd0, blad_parz}, {31'd0, e.perr});
        chk("blad_ramki", {31'd0, blad_ramki}, {31'd0, e.ferr});
      end
    end else if (blad_parz || blad_ramki) begin
      chk("flags_without_gotowe", {30'd0, blad_parz, blad_ramki}, 32'd0);
    end
  end

  task automatic drive(input logic b, input int n);
    wejscie_odb = b;
    repeat (n) @(negedge CLK);
  endtask

  // One frame; bad_par inverts the correct parity bit, flip toggles jaki_parz mid-frame
  task automatic send_frame(input logic [7:0] d, input logic bad_par, input logic stop_bit,
                            input int stop_len, input logic flip);
    exp_t e;
    logic pen;
    logic pb;
    pen    = czy_parz;
    pb     = (^d) ^ jaki_parz ^ bad_par;
    e.d    = d;
    e.perr = pen & bad_par;
    e.ferr = ~stop_bit;
    sb.push_back(e);
    drive(1'b0, CPB);
    chk("odbior_busy", {31'd0, odbior}, 32'd1);
    if (flip) jaki_parz = ~jaki_parz;
    for (int i = 0; i < 8; i++) drive(d[i], CPB);
    if (pen) drive(pb, CPB);
    drive(stop_bit, stop_len);
    if (flip) jaki_parz = ~jaki_parz;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 64 && sb.size() != 0; i++) @(negedge CLK);
    chk("scoreboard_drained", sb.size(), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] abort_d;
    RST_N       = 1'b0;
    wejscie_odb = 1'b1;
    czy_parz    = 1'b0;
    jaki_parz   = 1'b0;
    repeat (3) @(negedge CLK);
    chk("rst_slowo_odb", {24'd0, slowo_odb}, 32'd0);
    chk("rst_gotowe", {31'd0, gotowe}, 32'd0);
    chk("rst_odbior", {31'd0, odbior}, 32'd0);
    chk("rst_blad_parz", {31'd0, blad_parz}, 32'd0);
    chk("rst_blad_ramki", {31'd0, blad_ramki}, 32'd0);
    RST_N = 1'b1;
    repeat (5) @(negedge CLK);

    // Odd parity, correct parity bit
    czy_parz  = 1'b1;
    jaki_parz = 1'b1;
    send_frame(8'h99, 1'b0, 1'b1, CPB, 1'b0);
    drive(1'b1, 4);
    wait_drain();

    // Odd parity, wrong parity bit
    send_frame(8'h99, 1'b1, 1'b1, CPB, 1'b0);
    drive(1'b1, 4);
    wait_drain();

    // Even parity with jaki_parz toggled mid-frame: the captured mode must win
    jaki_parz = 1'b0;
    send_frame(8'h07, 1'b0, 1'b1, CPB, 1'b1);
    drive(1'b1, 4);
    wait_drain();

    // Framing error, line held low, then a clean frame
    czy_parz = 1'b0;
    send_frame(8'hA5, 1'b0, 1'b0, 40, 1'b0);
    chk("odbior_wait_idle", {31'd0, odbior}, 32'd0);
    drive(1'b1, CPB);
    wait_drain();
    send_frame(8'h3C, 1'b0, 1'b1, CPB, 1'b0);
    drive(1'b1, 4);
    wait_drain();

    // Short glitch on the idle line is a false start
    drive(1'b0, 4);
    chk("glitch_odbior_rise", {31'd0, odbior}, 32'd1);
    wejscie_odb = 1'b1;
    for (int i = 0; i < 8 && odbior; i++) @(negedge CLK);
    chk("glitch_odbior_drop", {31'd0, odbior}, 32'd0);
    drive(1'b1, 2 * CPB);
    chk("hold_after_glitch", {24'd0, slowo_odb}, 32'h3C);
    wait_drain();

    // Reset during data bit 4 aborts the frame at once
    abort_d = 8'hA3;
    drive(1'b0, CPB);
    for (int i = 0; i < 4; i++) drive(abort_d[i], CPB);
    drive(abort_d[4], 5);
    wejscie_odb = 1'b1;
    #2 RST_N = 1'b0;
    #1;
    chk("abort_odbior", {31'd0, odbior}, 32'd0);
    chk("abort_slowo_odb", {24'd0, slowo_odb}, 32'd0);
    chk("abort_gotowe", {31'd0, gotowe}, 32'd0);
    chk("abort_flags", {30'd0, blad_parz, blad_ramki}, 32'd0);
    @(negedge CLK);
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    drive(1'b1, CPB);
    send_frame(8'h55, 1'b0, 1'b1, CPB, 1'b0);
    drive(1'b1, 4);
    wait_drain();

    // Back-to-back frames with no idle gap
    send_frame(8'h00, 1'b0, 1'b1, CPB, 1'b0);
    send_frame(8'hFF, 1'b0, 1'b1, CPB, 1'b0);
    drive(1'b1, 4);
    wait_drain();
    chk("b2b_gap", t_last - t_prev, 32'd160);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
